// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microwave_pkg
// Purpose  : Shared types and constants for the microwave keypad front end.
//            Holds the entry-state encoding, the default heat time, the
//            largest accepted keypad digit and the power-level encoding.
// Contents : entry_state_t, DEFAULT_TIMER, MAX_DIGIT, POWER_HALF/POWER_FULL,
//            two_digit_value()
// Revision : 1.0  initial release
// ============================================================================
package microwave_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } entry_state_t;

  localparam logic [6:0] DEFAULT_TIMER = 7'd60;
  localparam logic [3:0] MAX_DIGIT     = 4'd9;
  localparam logic       POWER_HALF    = 1'b0;
  localparam logic       POWER_FULL    = 1'b1;

  // tens*10 + units using shifts; both inputs are <= 9, so the result
  // never exceeds 99 and fits in 7 bits.
  function automatic logic [6:0] two_digit_value(input logic [3:0] tens,
                                                 input logic [3:0] units);
    logic [6:0] t7;
    t7 = {3'b000, tens};
    return (t7 << 3) + (t7 << 1) + {3'b000, units};
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Two-flop synchronizer followed by a per-bit stability counter.
//            A bit's debounced level takes the synchronized value only after
//            DEBOUNCE_CYCLES consecutive synchronized samples that differ
//            from the current level; any reversion restarts the count.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            raw_i      - asynchronous raw input(s)
//            sync_o     - synchronized (not debounced) input(s)
//            level_o    - debounced level(s)
// Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] level_o
);

  // Counter reaching LIMIT on a differing sample means this sample is the
  // DEBOUNCE_CYCLES-th consecutive one, so the level flips on this edge.
  localparam logic [7:0] c_LIMIT = 8'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       level_q;
    logic       level_d;

    always_comb begin
      cnt_d   = 8'd0;
      level_d = level_q;
      if (sync_q[b] != level_q) begin
        if (cnt_q == c_LIMIT) begin
          level_d = sync_q[b];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= 8'd0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign level_o[b] = level_q;
  end

endmodule
`default_nettype wire

// File: rtl/microwave_keypad.sv
`default_nettype none
// ============================================================================
// Module   : microwave_keypad
// Purpose  : Keypad and door front end of a microwave controller. Cleans up
//            raw switches, turns button presses into single-cycle events and
//            runs the two-digit time-entry state machine plus power toggle.
// Ports    : clk, reset_n          - clock, async active-low reset
//            door_raw              - raw door switch (1 = closed)
//            start_raw, cancel_raw, power_raw, digit_press_raw - raw buttons
//            digit_raw[3:0]        - keypad code, valid with digit_press_raw
//            entry_enable          - controller is in a programming state
//            door_status           - debounced door level
//            start_button, cancel_button - one-cycle press pulses
//            power                 - 0 = half, 1 = full
//            timer[6:0]            - programmed heat time in seconds
// Revision : 1.0  initial release
// ============================================================================
module microwave_keypad
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       door_raw,
  input  logic       start_raw,
  input  logic       cancel_raw,
  input  logic       power_raw,
  input  logic       digit_press_raw,
  input  logic [3:0] digit_raw,
  input  logic       entry_enable,
  output logic       door_status,
  output logic       start_button,
  output logic       cancel_button,
  output logic       power,
  output logic [6:0] timer
);

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  logic       w_door_lvl, w_start_lvl, w_cancel_lvl, w_power_lvl, w_dpress_lvl;
  logic       w_door_sync_unused, w_start_sync_unused, w_cancel_sync_unused;
  logic       w_power_sync_unused, w_dpress_sync_unused;
  logic [3:0] w_digit_sync;
  logic [3:0] w_digit_lvl_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_db_door (
    .clk(clk), .reset_n(reset_n), .raw_i(door_raw),
    .sync_o(w_door_sync_unused), .level_o(w_door_lvl));

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_db_start (
    .clk(clk), .reset_n(reset_n), .raw_i(start_raw),
    .sync_o(w_start_sync_unused), .level_o(w_start_lvl));

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_db_cancel (
    .clk(clk), .reset_n(reset_n), .raw_i(cancel_raw),
    .sync_o(w_cancel_sync_unused), .level_o(w_cancel_lvl));

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_db_power (
    .clk(clk), .reset_n(reset_n), .raw_i(power_raw),
    .sync_o(w_power_sync_unused), .level_o(w_power_lvl));

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_db_dpress (
    .clk(clk), .reset_n(reset_n), .raw_i(digit_press_raw),
    .sync_o(w_dpress_sync_unused), .level_o(w_dpress_lvl));

  // The code bus is only sampled on a qualified press, so its synchronized
  // value is what matters; its debounced level is not used.
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(4)) u_db_digit (
    .clk(clk), .reset_n(reset_n), .raw_i(digit_raw),
    .sync_o(w_digit_sync), .level_o(w_digit_lvl_unused));

  // ------------------------------------------------------------------
  // Press detection: debounced 0->1 transitions
  // ------------------------------------------------------------------
  logic start_prev_q, cancel_prev_q, power_prev_q, dpress_prev_q;
  logic w_start_rise, w_cancel_rise, w_power_rise, w_digit_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q  <= 1'b0;
      cancel_prev_q <= 1'b0;
      power_prev_q  <= 1'b0;
      dpress_prev_q <= 1'b0;
    end else begin
      start_prev_q  <= w_start_lvl;
      cancel_prev_q <= w_cancel_lvl;
      power_prev_q  <= w_power_lvl;
      dpress_prev_q <= w_dpress_lvl;
    end
  end

  assign w_start_rise  = w_start_lvl  & ~start_prev_q;
  assign w_cancel_rise = w_cancel_lvl & ~cancel_prev_q;
  assign w_power_rise  = w_power_lvl  & ~power_prev_q;
  assign w_digit_rise  = w_dpress_lvl & ~dpress_prev_q;

  // ------------------------------------------------------------------
  // Entry FSM: state register
  // ------------------------------------------------------------------
  entry_state_t state_q, state_d;
  logic [3:0]   units_q, units_d;
  logic [3:0]   tens_q, tens_d;
  logic         power_q, power_d;
  logic         start_button_q, start_button_d;
  logic         cancel_button_q, cancel_button_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= EMPTY;
      units_q         <= 4'd0;
      tens_q          <= 4'd0;
      power_q         <= POWER_HALF;
      start_button_q  <= 1'b0;
      cancel_button_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      units_q         <= units_d;
      tens_q          <= tens_d;
      power_q         <= power_d;
      start_button_q  <= start_button_d;
      cancel_button_q <= cancel_button_d;
    end
  end

  // ------------------------------------------------------------------
  // Entry FSM: next-state logic. Cancel has priority over every other
  // event in the same cycle; start is dropped outside programming states.
  // ------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    units_d         = units_q;
    tens_d          = tens_q;
    power_d         = power_q;
    cancel_button_d = w_cancel_rise;
    start_button_d  = w_start_rise & entry_enable & ~w_cancel_rise;

    if (w_cancel_rise) begin
      state_d = EMPTY;
      units_d = 4'd0;
      tens_d  = 4'd0;
      power_d = POWER_HALF;
    end else if (entry_enable) begin
      if (w_power_rise) begin
        power_d = (power_q == POWER_FULL) ? POWER_HALF : POWER_FULL;
      end
      if (w_digit_rise && (w_digit_sync <= MAX_DIGIT)) begin
        case (state_q)
          EMPTY: begin
            units_d = w_digit_sync;
            state_d = ONE;
          end
          ONE: begin
            tens_d  = units_q;
            units_d = w_digit_sync;
            state_d = TWO;
          end
          default: begin
            // Entry full: further digits are discarded.
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------------------
  // Entry FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    timer = DEFAULT_TIMER;
    case (state_q)
      ONE:     timer = {3'b000, units_q};
      TWO:     timer = two_digit_value(tens_q, units_q);
      default: timer = DEFAULT_TIMER;
    endcase
  end

  assign power         = power_q;
  assign start_button  = start_button_q;
  assign cancel_button = cancel_button_q;
  assign door_status   = w_door_lvl;

endmodule
`default_nettype wire

// File: tb/tb_microwave_keypad.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_keypad
// Purpose  : Directed self-checking bench for microwave_keypad with the
//            default debounce length of 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_microwave_keypad;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       door_raw = 1'b0;
  logic       start_raw = 1'b0;
  logic       cancel_raw = 1'b0;
  logic       power_raw = 1'b0;
  logic       digit_press_raw = 1'b0;
  logic [3:0] digit_raw = 4'd0;
  logic       entry_enable = 1'b0;
  logic       door_status;
  logic       start_button;
  logic       cancel_button;
  logic       power;
  logic [6:0] timer;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  microwave_keypad #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .door_raw(door_raw), .start_raw(start_raw), .cancel_raw(cancel_raw),
    .power_raw(power_raw), .digit_press_raw(digit_press_raw),
    .digit_raw(digit_raw), .entry_enable(entry_enable),
    .door_status(door_status), .start_button(start_button),
    .cancel_button(cancel_button), .power(power), .timer(timer)
  );

  // Rising-edge counter and pulse monitors (sampled mid-cycle).
  int   cyc = 0;
  int   start_seen = 0, start_last = 0;
  int   cancel_seen = 0, cancel_last = 0;
  int   door_rises = 0, door_last = 0;
  logic door_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_button === 1'b1) begin
      start_seen <= start_seen + 1;
      start_last <= cyc;
    end
    if (cancel_button === 1'b1) begin
      cancel_seen <= cancel_seen + 1;
      cancel_last <= cyc;
    end
    if (door_status === 1'b1 && door_prev === 1'b0) begin
      door_rises <= door_rises + 1;
      door_last  <= cyc;
    end
    door_prev <= door_status;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_raw(input int sel, input logic v);
    case (sel)
      0: start_raw = v;
      1: cancel_raw = v;
      2: power_raw = v;
      default: digit_press_raw = v;
    endcase
  endtask

  // Hold a button for `hold` cycles, release it and let it settle.
  task automatic press(input int sel, input int hold);
    set_raw(sel, 1'b1);
    step(hold);
    set_raw(sel, 1'b0);
    step(10);
  endtask

  task automatic press_digit(input logic [3:0] d);
    digit_raw = d;
    press(3, 10);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(2);
    checks++; if (timer !== 7'd60) begin failures++; $display("FAIL reset_timer got=%0d exp=60", timer); end
    checks++; if (power !== 1'b0) begin failures++; $display("FAIL reset_power got=%b exp=0", power); end
    checks++; if (start_button !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start_button); end
    checks++; if (cancel_button !== 1'b0) begin failures++; $display("FAIL reset_cancel got=%b exp=0", cancel_button); end
    checks++; if (door_status !== 1'b0) begin failures++; $display("FAIL reset_door got=%b exp=0", door_status); end
    reset_n = 1'b1;
    step(8);
    checks++; if (timer !== 7'd60 || power !== 1'b0) begin failures++; $display("FAIL idle_outputs got timer=%0d power=%b exp 60/0", timer, power); end
    checks++; if (start_seen != 0 || cancel_seen != 0) begin failures++; $display("FAIL idle_pulses got start=%0d cancel=%0d exp 0/0", start_seen, cancel_seen); end
  endtask

  task automatic test_digits;
    entry_enable = 1'b1;
    press_digit(4'd4);
    checks++; if (timer !== 7'd4) begin failures++; $display("FAIL digit_first got=%0d exp=4", timer); end
    press_digit(4'd5);
    checks++; if (timer !== 7'd45) begin failures++; $display("FAIL digit_second got=%0d exp=45", timer); end
    press_digit(4'd7);
    checks++; if (timer !== 7'd45) begin failures++; $display("FAIL digit_full got=%0d exp=45", timer); end
    press_digit(4'd12);
    checks++; if (timer !== 7'd45) begin failures++; $display("FAIL digit_code12 got=%0d exp=45", timer); end
  endtask

  task automatic test_reset_mid_entry;
    int c0, s0;
    press(2, 10);
    checks++; if (power !== 1'b1) begin failures++; $display("FAIL pre_reset_power got=%b exp=1", power); end
    start_raw = 1'b1;
    step(3);
    reset_n = 1'b0;
    #1;
    checks++; if (timer !== 7'd60 || power !== 1'b0 || start_button !== 1'b0) begin
      failures++; $display("FAIL async_reset got timer=%0d power=%b start=%b exp 60/0/0", timer, power, start_button);
    end
    step(2);
    s0 = start_seen;
    reset_n = 1'b1;
    c0 = cyc;
    step(12);
    checks++; if (start_seen != s0 + 1) begin failures++; $display("FAIL post_reset_start_count got=%0d exp=%0d", start_seen - s0, 1); end
    checks++; if (start_last != c0 + 7) begin failures++; $display("FAIL post_reset_start_edge got=%0d exp=7", start_last - c0); end
    start_raw = 1'b0;
    step(10);
  endtask

  task automatic test_glitch;
    int c0, s0;
    s0 = start_seen;
    start_raw = 1'b1;
    step(2);
    start_raw = 1'b0;
    step(10);
    checks++; if (start_seen != s0) begin failures++; $display("FAIL glitch_start got=%0d exp=0", start_seen - s0); end
    c0 = cyc;
    start_raw = 1'b1;
    step(10);
    start_raw = 1'b0;
    step(10);
    checks++; if (start_seen != s0 + 1) begin failures++; $display("FAIL hold_start_count got=%0d exp=1", start_seen - s0); end
    checks++; if (start_last != c0 + 7) begin failures++; $display("FAIL hold_start_edge got=%0d exp=7", start_last - c0); end
  endtask

  task automatic test_power;
    int s0;
    press(2, 10);
    checks++; if (power !== 1'b1) begin failures++; $display("FAIL power_toggle1 got=%b exp=1", power); end
    press(2, 10);
    checks++; if (power !== 1'b0) begin failures++; $display("FAIL power_toggle2 got=%b exp=0", power); end
    press(2, 10);
    entry_enable = 1'b0;
    press(2, 10);
    checks++; if (power !== 1'b1) begin failures++; $display("FAIL power_disabled got=%b exp=1", power); end
    s0 = start_seen;
    press(0, 10);
    checks++; if (start_seen != s0) begin failures++; $display("FAIL start_disabled got=%0d exp=0", start_seen - s0); end
    press_digit(4'd3);
    checks++; if (timer !== 7'd60) begin failures++; $display("FAIL digit_disabled got=%0d exp=60", timer); end
    entry_enable = 1'b1;
  endtask

  task automatic test_cancel_start;
    int c0, s0, k0;
    press_digit(4'd3);
    press_digit(4'd0);
    checks++; if (timer !== 7'd30 || power !== 1'b1) begin failures++; $display("FAIL pre_cancel got timer=%0d power=%b exp 30/1", timer, power); end
    s0 = start_seen;
    k0 = cancel_seen;
    c0 = cyc;
    start_raw = 1'b1;
    cancel_raw = 1'b1;
    step(10);
    start_raw = 1'b0;
    cancel_raw = 1'b0;
    step(10);
    checks++; if (cancel_seen != k0 + 1) begin failures++; $display("FAIL cancel_count got=%0d exp=1", cancel_seen - k0); end
    checks++; if (cancel_last != c0 + 7) begin failures++; $display("FAIL cancel_edge got=%0d exp=7", cancel_last - c0); end
    checks++; if (start_seen != s0) begin failures++; $display("FAIL cancel_start_suppress got=%0d exp=0", start_seen - s0); end
    checks++; if (timer !== 7'd60 || power !== 1'b0) begin failures++; $display("FAIL cancel_clear got timer=%0d power=%b exp 60/0", timer, power); end
  endtask

  task automatic test_digit_start;
    digit_raw = 4'd8;
    digit_press_raw = 1'b1;
    start_raw = 1'b1;
    step(6);
    checks++; if (timer !== 7'd60 || start_button !== 1'b0) begin failures++; $display("FAIL digit_start_early got timer=%0d start=%b exp 60/0", timer, start_button); end
    step(1);
    checks++; if (timer !== 7'd8 || start_button !== 1'b1) begin failures++; $display("FAIL digit_start_same got timer=%0d start=%b exp 8/1", timer, start_button); end
    step(1);
    checks++; if (start_button !== 1'b0) begin failures++; $display("FAIL digit_start_width got=%b exp=0", start_button); end
    digit_press_raw = 1'b0;
    start_raw = 1'b0;
    step(10);
  endtask

  task automatic test_door;
    int c0, d0;
    d0 = door_rises;
    door_raw = 1'b1; step(1);
    door_raw = 1'b0; step(1);
    door_raw = 1'b1; step(1);
    door_raw = 1'b0; step(1);
    door_raw = 1'b1;
    c0 = cyc;
    step(5);
    checks++; if (door_status !== 1'b0) begin failures++; $display("FAIL door_early got=%b exp=0", door_status); end
    step(1);
    checks++; if (door_status !== 1'b1) begin failures++; $display("FAIL door_edge6 got=%b exp=1", door_status); end
    step(10);
    checks++; if (door_rises != d0 + 1 || door_last != c0 + 6) begin
      failures++; $display("FAIL door_once got rises=%0d edge=%0d exp 1/6", door_rises - d0, door_last - c0);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_reset_mid_entry();
    test_glitch();
    test_power();
    test_cancel_start();
    test_digit_start();
    test_door();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microwave_keypad.md
MICROWAVE_KEYPAD -- requirements
Module: microwave_keypad

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable samples needed to accept a new input level (legal range 1..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 door_raw  input  1  raw door switch; 1 = closed, 0 = open.
REQ-005 start_raw, cancel_raw, power_raw, digit_press_raw  input  1 each  raw buttons; 1 = pressed.
REQ-006 digit_raw  input  4  keypad digit code, sampled with digit_press_raw.
REQ-007 entry_enable  input  1  high while the controller is in a programming state (idle or reprogram).
REQ-008 door_status  output  1  debounced door level.
REQ-009 start_button, cancel_button  output  1 each  single-cycle press pulses.
REQ-010 power  output  1  0 = HALF, 1 = FULL.
REQ-011 timer  output  7  programmed heat time in seconds, 0..99.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level SHALL change on edge 2+DEBOUNCE_CYCLES after the first edge that samples the new raw level, provided that level holds throughout.
REQ-013 A raw glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT change the debounced level; any reversion SHALL restart the count.
REQ-014 door_status SHALL equal the debounced door level, with no further delay.
REQ-015 Press events SHALL be debounced 0->1 transitions, registered once; each pulse output SHALL be high for exactly one cycle at edge 3+DEBOUNCE_CYCLES.
REQ-016 Releases SHALL generate no event, and holding a button SHALL generate no repeat.
REQ-017 cancel_button SHALL pulse on every cancel press, regardless of entry_enable.
REQ-018 start_button SHALL pulse on a start press only when entry_enable is high; otherwise the press is dropped.
REQ-019 The entry FSM SHALL have states EMPTY, ONE, TWO.
REQ-020 In EMPTY, timer SHALL be 60; in ONE, timer SHALL be units; in TWO, timer SHALL be tens*10+units, computed in 7 bits without overflow.
REQ-021 A digit press SHALL latch the synchronized digit_raw from the cycle the debounced press rises.
REQ-022 A digit press with entry_enable high and digit <= 9 SHALL do: in EMPTY, units=d and go to ONE; in ONE, tens=units, units=d and go to TWO; in TWO, nothing (entry full).
REQ-023 Digit codes 10..15, and any digit press with entry_enable low, SHALL be ignored.
REQ-024 A power press with entry_enable high SHALL toggle power; with entry_enable low it SHALL be ignored.
REQ-025 A cancel press SHALL return the FSM to EMPTY (timer 60) and clear power to 0 on the same edge its pulse is registered.
REQ-026 Cancel with start on the same cycle: the cancel pulse and clear SHALL apply, and start SHALL be suppressed.
REQ-027 Cancel with a digit or power press on the same cycle: cancel SHALL win.
REQ-028 Digit press with start on the same cycle: the digit SHALL be applied, and the start pulse and updated timer SHALL be visible on the same cycle.
REQ-029 timer and power SHALL hold their values while entry_enable is low, so the controller sees them stable during cooking.

Reset
REQ-030 reset_n low SHALL immediately force: synchronizers and debounced levels to 0, debounce counters to 0, FSM to EMPTY, timer to 60, power to 0, and start_button, cancel_button and door_status to 0.
REQ-031 Reset asserted mid-debounce or mid-entry SHALL discard all partial state.
REQ-032 The first post-reset events SHALL require full debounce qualification.

Structure
REQ-033 Package microwave_pkg SHALL hold entry_state_t (EMPTY, ONE, TWO), DEFAULT_TIMER = 60, MAX_DIGIT = 9, and POWER_HALF = 0 / POWER_FULL = 1.
REQ-034 One sub-module, key_debounce (synchronizer plus counter, parameterized by DEBOUNCE_CYCLES), SHALL be instantiated once per raw input (6 instances).

Verification
REQ-035 Reset, then idle: timer = 60, power = 0, all pulses 0; assert reset_n low mid-entry -> outputs return to reset values immediately.
REQ-036 entry_enable = 1; press 4, then 5, then 7 -> timer 4, then 45, then stays 45; press code 12 -> no change.
REQ-037 2-cycle glitch on start_raw with DEBOUNCE_CYCLES = 4 -> no pulse; 10-cycle hold -> exactly one start_button pulse at edge 7.
REQ-038 Power press twice with entry_enable = 1 -> power 1, then 0; power press with entry_enable = 0 -> power unchanged, and a start press gives no pulse.
REQ-039 Cancel and start pressed on the same cycle after entering 30 with power = 1 -> cancel pulse only, timer 60, power 0.
REQ-040 Close door_raw (1) with a 3-cycle bounce, then stable -> door_status rises once, at edge 6 after the final transition.
